// File: rtl/rf_write_arbiter.sv
// Register-file write-port owner: clears every register after reset, then arbitrates
// writeback, multi-cycle unit and debug writes onto a single registered rf write port.
module rf_write_arbiter #(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 3,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    output logic              wb_stall,
    input  logic              mc_valid,
    input  logic [REG_AW-1:0] mc_reg,
    input  logic [DATA_W-1:0] mc_data,
    output logic              mc_ready,
    input  logic              dbg_valid,
    input  logic [REG_AW-1:0] dbg_reg,
    input  logic [DATA_W-1:0] dbg_data,
    output logic              dbg_ready,
    output logic [REG_AW-1:0] rf_write_reg,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              rf_write_en,
    output logic              init_done
);

    localparam int NUM_REGS = 2 ** REG_AW;
    localparam int WAIT_W   = $clog2(MAX_WAIT + 1);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [REG_AW-1:0] LAST_REG = REG_AW'(NUM_REGS - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    logic [0:0]        state_q, state_d;
    logic [REG_AW-1:0] clr_cnt_q, clr_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

    logic              wr_en_q, wr_en_d;
    logic [REG_AW-1:0] wr_reg_q, wr_reg_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    logic              stall_c;
    logic              mc_grant;
    logic              dbg_grant;
    logic              force_mc;

    // mc has waited long enough: it wins over writeback for exactly one cycle
    assign force_mc = (wait_cnt_q == WAIT_MAX) && mc_valid;

    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        wait_cnt_d = wait_cnt_q;
        wr_en_d    = 1'b0;
        wr_reg_d   = '0;
        wr_data_d  = '0;
        stall_c    = 1'b1;
        mc_grant   = 1'b0;
        dbg_grant  = 1'b0;

        case (state_q)
            ST_INIT: begin
                wr_en_d   = 1'b1;
                wr_reg_d  = clr_cnt_q;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == LAST_REG) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                stall_c = 1'b0;
                if (force_mc) begin
                    mc_grant = 1'b1;
                    stall_c  = 1'b1;
                end else if (wb_valid) begin
                    wr_en_d   = 1'b1;
                    wr_reg_d  = wb_reg;
                    wr_data_d = wb_data;
                end else if (mc_valid) begin
                    mc_grant = 1'b1;
                end else if (dbg_valid) begin
                    dbg_grant = 1'b1;
                    wr_en_d   = 1'b1;
                    wr_reg_d  = dbg_reg;
                    wr_data_d = dbg_data;
                end

                if (mc_grant) begin
                    wr_en_d   = 1'b1;
                    wr_reg_d  = mc_reg;
                    wr_data_d = mc_data;
                end

                if (!mc_valid || mc_grant) begin
                    wait_cnt_d = '0;
                end else if (wait_cnt_q != WAIT_MAX) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_INIT;
            clr_cnt_q  <= '0;
            wait_cnt_q <= '0;
            wr_en_q    <= 1'b0;
            wr_reg_q   <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            wr_en_q    <= wr_en_d;
            wr_reg_q   <= wr_reg_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign wb_stall      = stall_c;
    assign mc_ready      = mc_grant;
    assign dbg_ready     = dbg_grant;
    assign rf_write_en   = wr_en_q;
    assign rf_write_reg  = wr_reg_q;
    assign rf_write_data = wr_data_q;
    assign init_done     = (state_q == ST_RUN);

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: expected rf writes are queued when a cycle is
// driven and popped against the registered rf port one clock later.
module tb_rf_write_arbiter;

    localparam int DATA_W = 32;
    localparam int REG_AW = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              wb_valid, mc_valid, dbg_valid;
    logic [REG_AW-1:0] wb_reg, mc_reg, dbg_reg;
    logic [DATA_W-1:0] wb_data, mc_data, dbg_data;
    logic              wb_stall, mc_ready, dbg_ready;
    logic [REG_AW-1:0] rf_write_reg;
    logic [DATA_W-1:0] rf_write_data;
    logic              rf_write_en;
    logic              init_done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [REG_AW+DATA_W:0] exp_q[$];

    rf_write_arbiter #(.DATA_W(DATA_W), .REG_AW(REG_AW), .MAX_WAIT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .wb_valid     (wb_valid),
        .wb_reg       (wb_reg),
        .wb_data      (wb_data),
        .wb_stall     (wb_stall),
        .mc_valid     (mc_valid),
        .mc_reg       (mc_reg),
        .mc_data      (mc_data),
        .mc_ready     (mc_ready),
        .dbg_valid    (dbg_valid),
        .dbg_reg      (dbg_reg),
        .dbg_data     (dbg_data),
        .dbg_ready    (dbg_ready),
        .rf_write_reg (rf_write_reg),
        .rf_write_data(rf_write_data),
        .rf_write_en  (rf_write_en),
        .init_done    (init_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic wv, input logic [REG_AW-1:0] wr, input logic [DATA_W-1:0] wd,
                         input logic mv, input logic [REG_AW-1:0] mr, input logic [DATA_W-1:0] md,
                         input logic dv, input logic [REG_AW-1:0] dr, input logic [DATA_W-1:0] dd);
        wb_valid = wv;  wb_reg = wr;  wb_data = wd;
        mc_valid = mv;  mc_reg = mr;  mc_data = md;
        dbg_valid = dv; dbg_reg = dr; dbg_data = dd;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    // Called at a negedge: checks this cycle's handshakes, queues the rf write they
    // should produce, then checks the rf port after the following rising edge.
    task automatic step(input string tag, input logic es, input logic emr, input logic edr,
                        input logic ee, input logic [REG_AW-1:0] er, input logic [DATA_W-1:0] ed);
        logic [REG_AW+DATA_W:0] e;
        #1;
        chk({tag, ".wb_stall"},  wb_stall,  es);
        chk({tag, ".mc_ready"},  mc_ready,  emr);
        chk({tag, ".dbg_ready"}, dbg_ready, edr);
        exp_q.push_back({ee, er, ed});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk({tag, ".rf_en"},   rf_write_en,   e[REG_AW+DATA_W]);
        chk({tag, ".rf_reg"},  rf_write_reg,  e[REG_AW+DATA_W-1:DATA_W]);
        chk({tag, ".rf_data"}, rf_write_data, e[DATA_W-1:0]);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst.rf_en",     rf_write_en,   1'b0);
        chk("rst.rf_reg",    rf_write_reg,  '0);
        chk("rst.rf_data",   rf_write_data, '0);
        chk("rst.wb_stall",  wb_stall,      1'b1);
        chk("rst.mc_ready",  mc_ready,      1'b0);
        chk("rst.dbg_ready", dbg_ready,     1'b0);
        chk("rst.init_done", init_done,     1'b0);

        // 1: clear sequence; requests during INIT are ignored
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 3'd4, 32'h1234_5678, 1'b1, 3'd2, 32'h0BAD_0BAD, 1'b1, 3'd1, 32'hFFFF_0000);
        for (int i = 0; i < 8; i++) begin
            chk("clr.init_done", init_done, 1'b0);
            step("clr", 1'b1, 1'b0, 1'b0, 1'b1, REG_AW'(i), '0);
        end
        chk("clr.done", init_done, 1'b1);
        idle();
        step("idle", 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);

        // 2: lone writeback
        drive(1'b1, 3'd3, 32'hDEAD_BEEF, 1'b0, '0, '0, 1'b0, '0, '0);
        step("wb", 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 32'hDEAD_BEEF);
        idle();
        step("wb_idle", 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);

        // 3: wb and mc both valid -> four wb grants, then mc forced in with wb stalled
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 3'd1, 32'h1111_0000 + 32'(k), 1'b1, 3'd6, 32'hCAFE_0006, 1'b0, '0, '0);
            step("starve.wb", 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 32'h1111_0000 + 32'(k));
        end
        drive(1'b1, 3'd1, 32'h1111_0004, 1'b1, 3'd6, 32'hCAFE_0006, 1'b0, '0, '0);
        step("starve.mc", 1'b1, 1'b1, 1'b0, 1'b1, 3'd6, 32'hCAFE_0006);
        drive(1'b1, 3'd1, 32'h1111_0004, 1'b0, '0, '0, 1'b0, '0, '0);
        step("starve.wb_retry", 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 32'h1111_0004);

        // 4: mc beats dbg when wb is idle; dbg goes once mc drops
        drive(1'b0, '0, '0, 1'b1, 3'd5, 32'h5555_5555, 1'b1, 3'd2, 32'h0000_D0D0);
        step("dbg.mc_first", 1'b0, 1'b1, 1'b0, 1'b1, 3'd5, 32'h5555_5555);
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 3'd2, 32'h0000_D0D0);
        step("dbg.grant", 1'b0, 1'b0, 1'b1, 1'b1, 3'd2, 32'h0000_D0D0);
        idle();

        // 6: mc drops after three blocked cycles; counter restarts, so four more wb grants
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 3'd7, 32'h7700_0000 + 32'(k), 1'b1, 3'd4, 32'h4444_0000, 1'b0, '0, '0);
            step("wdrop.pre", 1'b0, 1'b0, 1'b0, 1'b1, 3'd7, 32'h7700_0000 + 32'(k));
        end
        drive(1'b1, 3'd7, 32'h7700_0003, 1'b0, '0, '0, 1'b0, '0, '0);
        step("wdrop.gap", 1'b0, 1'b0, 1'b0, 1'b1, 3'd7, 32'h7700_0003);
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 3'd0, 32'h8800_0000 + 32'(k), 1'b1, 3'd4, 32'h4444_0001, 1'b0, '0, '0);
            step("wdrop.post", 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 32'h8800_0000 + 32'(k));
        end
        drive(1'b1, 3'd0, 32'h8800_0004, 1'b1, 3'd4, 32'h4444_0001, 1'b0, '0, '0);
        step("wdrop.mc", 1'b1, 1'b1, 1'b0, 1'b1, 3'd4, 32'h4444_0001);
        idle();
        step("wdrop.idle", 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);

        // 5: reset during clear at clr_cnt=5 restarts the sweep from reg 0
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step("rclr.a", 1'b1, 1'b0, 1'b0, 1'b1, REG_AW'(i), '0);
        end
        drive(1'b1, 3'd6, 32'hAAAA_AAAA, 1'b1, 3'd6, 32'hBBBB_BBBB, 1'b0, '0, '0);
        rst = 1'b1;
        #1;
        chk("rclr.rst_en",   rf_write_en, 1'b0);
        chk("rclr.rst_done", init_done,   1'b0);
        chk("rclr.rst_mc",   mc_ready,    1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step("rclr.b", 1'b1, 1'b0, 1'b0, 1'b1, REG_AW'(i), '0);
        end
        chk("rclr.done", init_done, 1'b1);
        idle();
        step("rclr.idle", 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
